// File: rtl/mem_word_display_if.sv
// ROM read port shared by the instruction and data ROMs: one index out, two words back.
interface mem_word_display_if;
  logic [6:0]  rom_addr;
  logic [31:0] instr_rdata;
  logic [31:0] data_rdata;

  // Reader side: drives the index, receives both ROM words.
  modport master (
    output rom_addr,
    input  instr_rdata,
    input  data_rdata
  );

  // ROM side: samples the index, returns the words one edge later.
  modport slave (
    input  rom_addr,
    output instr_rdata,
    output data_rdata
  );
endinterface

// File: rtl/mem_word_display.sv
// Fetches the addressed ROM word and shows it as 8 hex digits on a
// multiplexed active-low seven-segment display; echoes the address on LEDs.
module mem_word_display #(
  parameter int unsigned SCAN_DIV = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          addr,
  mem_word_display_if.master  rom,
  output logic [31:0]         word,
  output logic                word_valid,
  output logic [7:0]          led,
  output logic [7:0]          an_n,
  output logic [6:0]          seg_n,
  output logic                dp_n
);

  localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIGIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                load_req;
  logic                load_cap;
  logic                first_q;
  logic                sel_q;
  logic [6:0]          rom_addr_q;
  logic [7:0]          last_addr_q;
  logic [CNT_W-1:0]    scan_cnt_q;
  logic [DIGIT_W-1:0]  digit_q;

  assign rom.rom_addr = rom_addr_q;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch FSM next state: a changed (or first) address starts a 3-edge fetch.
  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    load_cap = 1'b0;
    case (state_q)
      IDLE: begin
        if (first_q || (addr != last_addr_q)) begin
          state_d  = REQ;
          load_req = 1'b1;
        end
      end
      REQ: state_d = CAP;
      CAP: begin
        state_d  = IDLE;
        load_cap = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch datapath: latch the request, then capture the selected ROM word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q     <= 1'b1;
      rom_addr_q  <= 7'd0;
      sel_q       <= 1'b0;
      last_addr_q <= 8'd0;
      word        <= 32'd0;
      word_valid  <= 1'b0;
      led         <= 8'd0;
    end else begin
      if (load_req) begin
        rom_addr_q <= addr[6:0];
        sel_q      <= addr[7];
      end
      if (load_cap) begin
        word        <= sel_q ? rom.data_rdata : rom.instr_rdata;
        last_addr_q <= {sel_q, rom_addr_q};
        led         <= {sel_q, rom_addr_q};
        word_valid  <= 1'b1;
        first_q     <= 1'b0;
      end
    end
  end

  // Digit scan: each digit stays lit for SCAN_DIV cycles, free-running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
    end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      digit_q    <= digit_q + DIGIT_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + CNT_W'(1);
    end
  end

  // Display drive: anode, segments and dot all switch in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !word_valid) begin
      an_n  <= 8'hFF;
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= ~(8'b1 << digit_q);
      seg_n <= hex_to_seg(word[{digit_q, 2'b00} +: 4]);
      dp_n  <= ~((digit_q == DIGIT_W'(0)) && led[7]);
    end
  end

endmodule

// File: tb/tb_mem_word_display.sv
// Randomized bench for mem_word_display against a transaction-level model.
module tb_mem_word_display;

  localparam int unsigned SCAN_DIV = 100;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [31:0] word;
  logic        word_valid;
  logic [7:0]  led;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  mem_word_display_if rom_if ();

  mem_word_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .rom        (rom_if),
    .word       (word),
    .word_valid (word_valid),
    .led        (led),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] instr_rom [128];
  logic [31:0] data_rom  [128];
  logic [6:0]  hex_tab   [16];

  // Synchronous-read ROMs.
  always @(posedge clk) begin
    rom_if.instr_rdata <= instr_rom[rom_if.rom_addr];
    rom_if.data_rdata  <= data_rom[rom_if.rom_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: fetch = 3 edges from the sampled address, display = time-sliced digits.
  bit          m_first = 1'b1;
  bit          m_valid;
  int          m_busy;
  int          m_n;
  logic [7:0]  m_last, m_pend, m_led;
  logic [6:0]  m_rom_addr;
  logic [31:0] m_word, m_data;
  logic [7:0]  m_an = 8'hFF;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;

  always @(posedge clk) begin
    int dg;
    if (!rst_n) begin
      m_first = 1'b1; m_valid = 1'b0; m_busy = 0; m_n = 0;
      m_last = 8'h00; m_led = 8'h00; m_word = 32'h0; m_rom_addr = 7'h00;
      m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      dg = (m_n / SCAN_DIV) % 8;
      if (m_valid) begin
        m_an  = ~(8'h01 << dg);
        m_seg = hex_tab[m_word[dg*4 +: 4]];
        m_dp  = ~((dg == 0) && m_led[7]);
      end else begin
        m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
      end
      m_n++;
      if (m_busy == 0) begin
        if (m_first || addr != m_last) begin
          m_pend = addr; m_rom_addr = addr[6:0]; m_busy = 2;
        end
      end else if (m_busy == 2) begin
        m_data = m_pend[7] ? data_rom[m_pend[6:0]] : instr_rom[m_pend[6:0]];
        m_busy = 1;
      end else begin
        m_word = m_data; m_last = m_pend; m_led = m_pend;
        m_valid = 1'b1; m_first = 1'b0; m_busy = 0;
      end
    end
  end

  bit mon_en = 1'b0;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rom_addr",   32'(rom_if.rom_addr), 32'(m_rom_addr));
      check("word",       word,                 m_word);
      check("word_valid", 32'(word_valid),      32'(m_valid));
      check("led",        32'(led),             32'(m_led));
      check("an_n",       32'(an_n),            32'(m_an));
      check("seg_n",      32'(seg_n),           32'(m_seg));
      check("dp_n",       32'(dp_n),            32'(m_dp));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [7:0] val, input int budget);
    int k = 0;
    while (an_n !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_an_timeout", 32'(an_n), 32'(val));
  endtask

  initial begin
    int viol, dpcnt;
    logic [7:0] an_exp;
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < 128; i++) begin
      instr_rom[i] = $urandom;
      data_rom[i]  = $urandom;
    end
    instr_rom[0] = 32'hE3A0_1234;
    instr_rom[1] = 32'h0123_4567;
    data_rom[0]  = 32'hFFFF_0008;
    instr_rom[5] = 32'h5555_AAA5;
    instr_rom[6] = 32'h6666_1234;

    // Reset and first fetch.
    rst_n = 1'b0;
    addr  = 8'h00;
    step(3);
    mon_en = 1'b1;
    check("rst_word",  word, 32'h0);
    check("rst_an",    32'(an_n), 32'hFF);
    check("rst_seg",   32'(seg_n), 32'h7F);
    check("rst_dp",    32'(dp_n), 32'h1);
    rst_n = 1'b1;
    step(1);
    check("first_rom_addr", 32'(rom_if.rom_addr), 32'h0);
    check("first_valid_e0", 32'(word_valid), 32'h0);
    step(1);
    check("first_an_blank", 32'(an_n), 32'hFF);
    step(1);
    check("first_word",  word, 32'hE3A0_1234);
    check("first_valid", 32'(word_valid), 32'h1);
    check("first_led",   32'(led), 32'h00);
    step(1);
    check("first_an_lit",  32'(an_n), 32'hFE);
    check("first_seg_lit", 32'(seg_n), 32'b0011001);

    // Scan through all eight digits of 0x01234567.
    addr = 8'h01;
    step(5);
    wait_an(8'hFE, 10 * SCAN_DIV);
    for (int d = 0; d < 8; d++) begin
      an_exp = ~(8'h01 << d);
      check("scan_an",  32'(an_n), 32'(an_exp));
      check("scan_seg", 32'(seg_n), 32'(hex_tab[7 - d]));
      check("scan_dp",  32'(dp_n), 32'h1);
      step(SCAN_DIV);
    end

    // Instruction ROM top word to data ROM word 0.
    addr = 8'h7F;
    step(5);
    addr = 8'h80;
    step(5);
    check("sw_rom_addr", 32'(rom_if.rom_addr), 32'h00);
    check("sw_led",      32'(led), 32'h80);
    check("sw_word",     word, 32'hFFFF_0008);
    viol = 0;
    dpcnt = 0;
    for (int i = 0; i < 8 * int'(SCAN_DIV); i++) begin
      if (dp_n == 1'b0 && an_n != 8'hFE) viol++;
      if (dp_n == 1'b0) dpcnt++;
      step(1);
    end
    check("dp_only_digit0", 32'(viol), 32'd0);
    check("dp_cycles",      32'(dpcnt), 32'(SCAN_DIV));

    // Address change while a fetch is in flight.
    addr = 8'h05;
    step(1);
    addr = 8'h06;
    step(2);
    check("mid_word5", word, 32'h5555_AAA5);
    check("mid_led5",  32'(led), 32'h05);
    step(2);
    check("mid_hold5", word, 32'h5555_AAA5);
    step(1);
    check("mid_word6", word, 32'h6666_1234);
    check("mid_led6",  32'(led), 32'h06);

    // Reset while in CAP aborts the fetch; the address is refetched after.
    addr = 8'h21;
    step(2);
    rst_n = 1'b0;
    step(1);
    check("rmid_word",  word, 32'h0);
    check("rmid_valid", 32'(word_valid), 32'h0);
    check("rmid_led",   32'(led), 32'h0);
    check("rmid_an",    32'(an_n), 32'hFF);
    check("rmid_addr",  32'(rom_if.rom_addr), 32'h0);
    rst_n = 1'b1;
    step(3);
    check("rmid_refetch", word, instr_rom[8'h21]);
    check("rmid_led21",   32'(led), 32'h21);

    // Stable address held for a long time.
    addr = 8'hBC;
    step(1000);
    check("stable_addr", 32'(rom_if.rom_addr), 32'h3C);
    check("stable_word", word, data_rom[7'h3C]);
    check("stable_led",  32'(led), 32'hBC);

    // Random address stream with occasional reset pulses.
    for (int t = 0; t < 300; t++) begin
      addr = 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step($urandom_range(1, 8));
    end
    step(10);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
